// File: rtl/serial_slt_alu_if.sv
// Handshake and operand/result bundle for the serial ADD/SUB/SLT/SLTU unit.
interface serial_slt_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] Result;
  logic             LT;
  logic             Overflow;
  logic             CarryOut;
  logic             Zero;
  logic             Illegal;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, ALUControl,
    input  Result, LT, Overflow, CarryOut, Zero, Illegal, busy, done
  );

  modport slave (
    input  start, A, B, ALUControl,
    output Result, LT, Overflow, CarryOut, Zero, Illegal, busy, done
  );
endinterface

// File: rtl/serial_slt_alu.sv
// Multi-cycle ADD/SUB/SLT/SLTU unit: STEP bits per clock through one shared
// STEP-bit ripple adder, WIDTH/STEP cycles per operation (WIDTH must be a
// multiple of STEP). Start/busy/done handshake, registered results.
module serial_slt_alu #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input logic             clk,
  input logic             reset,
  serial_slt_alu_if.slave bus
);
  localparam int CYCLES = WIDTH / STEP;
  localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // B already conditionally inverted for SUB/compare
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [2:0]       ctl_q, ctl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             lt_q, lt_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic             ill_q, ill_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [STEP:0]    chunk_sum;
  logic             last;
  logic             legal;
  logic             ov_raw;

  // Next-state: operand capture, one chunk addition per RUN cycle, flag/result update on the final chunk
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    ctl_d     = ctl_q;
    result_d  = result_q;
    lt_d      = lt_q;
    ovf_d     = ovf_q;
    cout_d    = cout_q;
    ill_d     = ill_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ov_raw    = 1'b0;
    chunk_sum = {1'b0, a_q[cnt_q*STEP +: STEP]}
              + {1'b0, b_q[cnt_q*STEP +: STEP]}
              + {{STEP{1'b0}}, carry_q};
    last      = (cnt_q == CW'(CYCLES - 1));
    legal     = (ctl_q == 3'b000) || (ctl_q == 3'b001) ||
                (ctl_q == 3'b101) || (ctl_q == 3'b111);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B ^ {WIDTH{bus.ALUControl[0]}};
          carry_d = bus.ALUControl[0];
          ctl_d   = bus.ALUControl;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[cnt_q*STEP +: STEP] = chunk_sum[STEP-1:0];
        carry_d = chunk_sum[STEP];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          // Operands of equal sign (after inversion) whose sum flips sign overflowed
          ov_raw  = ~(a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum_d[WIDTH-1] ^ a_q[WIDTH-1]);
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (legal) begin
            cout_d = chunk_sum[STEP];
            ovf_d  = ov_raw & ~ctl_q[1];
            if (ctl_q[2]) begin
              lt_d     = ctl_q[1] ? ~chunk_sum[STEP] : (sum_d[WIDTH-1] ^ ov_raw);
              result_d = {{(WIDTH-1){1'b0}}, lt_d};
            end else begin
              lt_d     = 1'b0;
              result_d = sum_d;
            end
            ill_d = 1'b0;
          end else begin
            result_d = '0;
            lt_d     = 1'b0;
            ovf_d    = 1'b0;
            cout_d   = 1'b0;
            ill_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural outputs: cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      lt_q     <= lt_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      ill_q    <= ill_d;
    end
  end

  // Datapath working registers: always reloaded on acceptance, so no reset needed
  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    a_q     <= a_d;
    b_q     <= b_d;
    sum_q   <= sum_d;
    carry_q <= carry_d;
    ctl_q   <= ctl_d;
  end

  assign bus.Result   = result_q;
  assign bus.LT       = lt_q;
  assign bus.Overflow = ovf_q;
  assign bus.CarryOut = cout_q;
  assign bus.Illegal  = ill_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.Zero     = (result_q == '0);
endmodule

// File: tb/tb_serial_slt_alu.sv
// Scoreboard bench for serial_slt_alu: driver pushes model expectations,
// negedge monitor pops and compares on every done pulse.
module tb_serial_slt_alu;
  localparam int WIDTH  = 32;
  localparam int STEP   = 4;
  localparam int CYCLES = WIDTH / STEP;

  typedef struct {
    logic [31:0] res;
    logic        lt;
    logic        ov;
    logic        co;
    logic        ill;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   passed = 0;
  exp_t exp_q[$];
  exp_t prev;

  serial_slt_alu_if #(.WIDTH(WIDTH)) bus ();

  serial_slt_alu #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Reference behaviour from the arithmetic definitions of each operation
  function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    logic [32:0] s;
    logic [31:0] d;
    logic signed [31:0] sa, sb;
    logic sub_ov;
    sa = a; sb = b;
    d  = a - b;
    sub_ov = (a[31] != b[31]) && (d[31] != a[31]);
    m.res = '0; m.lt = 1'b0; m.ov = 1'b0; m.co = 1'b0; m.ill = 1'b0; m.due = 0;
    case (c)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        m.res = s[31:0]; m.co = s[32];
        m.ov = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'b001: begin m.res = d; m.co = (a >= b); m.ov = sub_ov; end
      3'b101: begin m.lt = (sa < sb); m.res = {31'b0, m.lt}; m.co = (a >= b); m.ov = sub_ov; end
      3'b111: begin m.lt = (a < b); m.res = {31'b0, m.lt}; m.co = (a >= b); end
      default: m.ill = 1'b1;
    endcase
    return m;
  endfunction

  // Monitor: every completion must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no completion", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc,          e.due);
        chk("busy_in_done", bus.busy,   1'b0);
        chk("result",   bus.Result,     e.res);
        chk("lt",       bus.LT,         e.lt);
        chk("overflow", bus.Overflow,   e.ov);
        chk("carryout", bus.CarryOut,   e.co);
        chk("illegal",  bus.Illegal,    e.ill);
        chk("zero",     bus.Zero,       (e.res == 0));
        prev = e;
      end
    end
  end

  // Start one op at the next edge; scramble inputs afterwards to show they are not re-sampled
  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.ALUControl = c;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.ALUControl = 3'($urandom);
    e = model(c, a, b);
    e.due = cyc + CYCLES;
    exp_q.push_back(e);
    chk("busy_after_start", bus.busy, 1'b1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4 * CYCLES + 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL done_timeout: %0d ops outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_zeroed(input string tag);
    chk({tag, "_result"}, bus.Result,   32'h0);
    chk({tag, "_lt"},     bus.LT,       1'b0);
    chk({tag, "_ovf"},    bus.Overflow, 1'b0);
    chk({tag, "_cout"},   bus.CarryOut, 1'b0);
    chk({tag, "_ill"},    bus.Illegal,  1'b0);
    chk({tag, "_zero"},   bus.Zero,     1'b1);
    chk({tag, "_busy"},   bus.busy,     1'b0);
    chk({tag, "_done"},   bus.done,     1'b0);
  endtask

  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};
  logic [2:0]  codes   [8] = '{3'b000, 3'b001, 3'b101, 3'b111, 3'b000, 3'b101, 3'b010, 3'b110};

  initial begin
    exp_t e;
    int   s;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.ALUControl = '0;
    prev.res = '0; prev.lt = 0; prev.ov = 0; prev.co = 0; prev.ill = 0; prev.due = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_zeroed("reset");
    reset = 1'b0;

    // Directed cases
    issue(3'b101, 32'hFFFFFFFF, 32'h1);        wait_done();
    issue(3'b101, 32'h80000000, 32'h1);        wait_done();
    issue(3'b111, 32'hFFFFFFFF, 32'h1);        wait_done();
    issue(3'b111, 32'h1,        32'hFFFFFFFF); wait_done();
    issue(3'b000, 32'h7FFFFFFF, 32'h1);        wait_done();
    issue(3'b001, 32'h5,        32'h5);        wait_done();

    // Start pulse at edge 3 of an op is ignored; outputs hold until done
    issue(3'b000, 32'h12345678, 32'h11111111);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'hDEADBEEF; bus.B = 32'h1; bus.ALUControl = 3'b001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ignored_start_busy", bus.busy, 1'b1);
    chk("hold_result", bus.Result, prev.res);
    chk("hold_carry",  bus.CarryOut, prev.co);
    wait_done();
    repeat (2 * CYCLES) @(negedge clk);

    // start held through the done cycle: second op accepted one edge after done
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'h00000010; bus.B = 32'h00000020; bus.ALUControl = 3'b101;
    @(posedge clk); #1;
    s = cyc;
    e = model(3'b101, 32'h10, 32'h20); e.due = s + CYCLES;         exp_q.push_back(e);
    bus.A = 32'hFFFFFFF0; bus.B = 32'h00000030; bus.ALUControl = 3'b001;
    e = model(3'b001, 32'hFFFFFFF0, 32'h30); e.due = s + 2 * CYCLES + 1; exp_q.push_back(e);
    repeat (CYCLES + 1) @(posedge clk);
    #1 bus.start = 1'b0;
    chk("b2b_second_busy", bus.busy, 1'b1);
    wait_done();

    // Asynchronous reset mid-op discards it
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'h7; bus.B = 32'h9; bus.ALUControl = 3'b000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_zeroed("async_reset");
    @(negedge clk);
    reset = 1'b0;
    prev.res = '0; prev.co = 0;
    repeat (2 * CYCLES) @(negedge clk);

    // Illegal code completes with zeroed outputs; next legal op clears Illegal
    issue(3'b010, 32'h3, 32'h3);               wait_done();
    issue(3'b000, 32'h3, 32'h4);               wait_done();

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      issue(codes[$urandom_range(0, 7)], a, b);
      wait_done();
    end

    repeat (2 * CYCLES) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
